// File: rtl/exc_redirect_ctrl_if.sv
// Redirect handshake between the exception controller (master) and the IF stage (slave).
interface exc_redirect_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/exc_redirect_ctrl.sv
// Exception / ertn redirect controller: flushes the front pipeline for one cycle,
// then holds a fetch redirect until IF accepts it. Keeps saturating event counters.
module exc_redirect_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wb_ex,
  input  logic [5:0]           wb_ecode,
  input  logic                 ertn_flush,
  input  logic [31:0]          csr_eentry,
  input  logic [31:0]          csr_era,
  exc_redirect_ctrl_if.master  rd,
  output logic                 flush_all,
  output logic                 busy,
  output logic [5:0]           last_ecode,
  output logic [CNT_W-1:0]     ex_cnt,
  output logic [CNT_W-1:0]     ertn_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int unsigned PC_W    = 32;
  localparam int unsigned ECODE_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    REDIR = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      target_q, target_d;
  logic [ECODE_W-1:0]   last_ecode_q, last_ecode_d;
  logic [CNT_W-1:0]     ex_cnt_q, ex_cnt_d;
  logic [CNT_W-1:0]     ertn_cnt_q, ertn_cnt_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic                 flush_all_q, flush_all_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic                 busy_q, busy_d;
  logic                 event_c;
  logic                 unused_eentry_c;

  // Entry address is 64-byte aligned; the low bits are never used.
  assign unused_eentry_c = ^csr_eentry[5:0];
  assign event_c         = wb_ex | ertn_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Next state, captured target and counters; output flops decode the next state.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    last_ecode_d = last_ecode_q;
    ex_cnt_d     = ex_cnt_q;
    ertn_cnt_d   = ertn_cnt_q;
    drop_cnt_d   = drop_cnt_q;

    case (state_q)
      IDLE: begin
        if (wb_ex) begin
          target_d     = {csr_eentry[31:6], 6'b0};
          last_ecode_d = wb_ecode;
          ex_cnt_d     = sat_inc(ex_cnt_q);
          state_d      = FLUSH;
        end else if (ertn_flush) begin
          target_d   = csr_era;
          ertn_cnt_d = sat_inc(ertn_cnt_q);
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        state_d = REDIR;
        if (event_c) drop_cnt_d = sat_inc(drop_cnt_q);
      end
      REDIR: begin
        if (rd.redirect_ready) state_d = IDLE;
        if (event_c) drop_cnt_d = sat_inc(drop_cnt_q);
      end
      default: state_d = IDLE;
    endcase

    flush_all_d      = (state_d == FLUSH);
    redirect_valid_d = (state_d == REDIR);
    busy_d           = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      target_q         <= '0;
      last_ecode_q     <= '0;
      ex_cnt_q         <= '0;
      ertn_cnt_q       <= '0;
      drop_cnt_q       <= '0;
      flush_all_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      target_q         <= target_d;
      last_ecode_q     <= last_ecode_d;
      ex_cnt_q         <= ex_cnt_d;
      ertn_cnt_q       <= ertn_cnt_d;
      drop_cnt_q       <= drop_cnt_d;
      flush_all_q      <= flush_all_d;
      redirect_valid_q <= redirect_valid_d;
      busy_q           <= busy_d;
    end
  end

  assign flush_all         = flush_all_q;
  assign busy              = busy_q;
  assign last_ecode        = last_ecode_q;
  assign ex_cnt            = ex_cnt_q;
  assign ertn_cnt          = ertn_cnt_q;
  assign drop_cnt          = drop_cnt_q;
  assign rd.redirect_valid = redirect_valid_q;
  assign rd.redirect_pc    = target_q;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed bench for exc_redirect_ctrl: a default-width and a 2-bit-counter instance
// share stimulus; redirect targets are scoreboarded and checked at each handshake.
module tb_exc_redirect_ctrl;

  logic        clk;
  logic        resetn;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic        ertn_flush;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;

  logic        flush_m, busy_m;
  logic [5:0]  ecode_m;
  logic [15:0] ex_m, ertn_m, drop_m;
  logic        flush_s, busy_s;
  logic [5:0]  ecode_s;
  logic [1:0]  ex_s, ertn_s, drop_s;

  int checks = 0;
  int errors = 0;
  int bc;
  logic [31:0] exp_q[$];

  exc_redirect_ctrl_if rif();
  exc_redirect_ctrl_if rif_s();

  exc_redirect_ctrl dut (
    .clk(clk), .resetn(resetn), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .ertn_flush(ertn_flush), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .rd(rif), .flush_all(flush_m), .busy(busy_m), .last_ecode(ecode_m),
    .ex_cnt(ex_m), .ertn_cnt(ertn_m), .drop_cnt(drop_m)
  );

  exc_redirect_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .resetn(resetn), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .ertn_flush(ertn_flush), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .rd(rif_s), .flush_all(flush_s), .busy(busy_s), .last_ecode(ecode_s),
    .ex_cnt(ex_s), .ertn_cnt(ertn_s), .drop_cnt(drop_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic r);
    rif.redirect_ready   = r;
    rif_s.redirect_ready = r;
  endtask

  // Handshake monitor: pops the scoreboard and checks flush/redirect exclusivity.
  always @(posedge clk) begin
    if (resetn === 1'b1) begin
      chk("flush_redir_excl", 32'(flush_m & rif.redirect_valid), 32'h0);
      if (rif.redirect_valid && rif.redirect_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_redirect", rif.redirect_pc, 32'hDEAD_BEEF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("redirect_pc_hs", rif.redirect_pc, e);
          chk("redirect_pc_hs_small", rif_s.redirect_pc, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    wb_ex      = 1'b0;
    wb_ecode   = 6'h0;
    ertn_flush = 1'b0;
    csr_eentry = 32'h0;
    csr_era    = 32'h0;
    set_ready(1'b0);
    step();
    step();
    chk("rst_flush", 32'(flush_m), 32'h0);
    chk("rst_valid", 32'(rif.redirect_valid), 32'h0);
    chk("rst_busy", 32'(busy_m), 32'h0);
    chk("rst_pc", rif.redirect_pc, 32'h0);
    chk("rst_cnts", 32'(ex_m) | 32'(ertn_m) | 32'(drop_m) | 32'(ecode_m), 32'h0);
    resetn = 1'b1;
    step();

    // Exception with immediate acceptance
    csr_eentry = 32'h1C00_8047; wb_ex = 1'b1; wb_ecode = 6'h0B; set_ready(1'b1);
    exp_q.push_back(32'h1C00_8040);
    step(); wb_ex = 1'b0;
    chk("ex_flush_t1", 32'(flush_m), 32'h1);
    chk("ex_valid_t1", 32'(rif.redirect_valid), 32'h0);
    chk("ex_busy_t1", 32'(busy_m), 32'h1);
    chk("ex_cnt_1", 32'(ex_m), 32'h1);
    chk("ex_ecode", 32'(ecode_m), 32'h0B);
    step();
    chk("ex_flush_t2", 32'(flush_m), 32'h0);
    chk("ex_valid_t2", 32'(rif.redirect_valid), 32'h1);
    chk("ex_pc_t2", rif.redirect_pc, 32'h1C00_8040);
    step();
    chk("ex_valid_t3", 32'(rif.redirect_valid), 32'h0);
    chk("ex_busy_t3", 32'(busy_m), 32'h0);

    // Ertn with four cycles of backpressure
    csr_era = 32'h1C00_0104; ertn_flush = 1'b1; set_ready(1'b0);
    exp_q.push_back(32'h1C00_0104);
    bc = 0;
    step(); ertn_flush = 1'b0;
    bc += int'(busy_m);
    chk("ertn_flush", 32'(flush_m), 32'h1);
    for (int r = 0; r < 5; r++) begin
      step();
      set_ready(r == 4);
      bc += int'(busy_m);
      chk("ertn_valid_held", 32'(rif.redirect_valid), 32'h1);
      chk("ertn_pc_held", rif.redirect_pc, 32'h1C00_0104);
    end
    step();
    bc += int'(busy_m);
    chk("ertn_valid_done", 32'(rif.redirect_valid), 32'h0);
    chk("ertn_busy_cycles", 32'(bc), 32'd6);
    chk("ertn_cnt_1", 32'(ertn_m), 32'h1);

    // Simultaneous exception and ertn: exception wins
    csr_era = 32'h0BAD_0000; wb_ex = 1'b1; ertn_flush = 1'b1; wb_ecode = 6'h15;
    exp_q.push_back(32'h1C00_8040);
    step(); wb_ex = 1'b0; ertn_flush = 1'b0;
    chk("sim_ex_cnt", 32'(ex_m), 32'h2);
    chk("sim_ertn_cnt", 32'(ertn_m), 32'h1);
    chk("sim_drop_cnt", 32'(drop_m), 32'h0);
    chk("sim_ecode", 32'(ecode_m), 32'h15);
    step();
    chk("sim_pc", rif.redirect_pc, 32'h1C00_8040);
    step();

    // Events while busy are dropped and leave target/ecode alone
    csr_eentry = 32'h8000_1234; wb_ex = 1'b1; wb_ecode = 6'h01; set_ready(1'b0);
    exp_q.push_back(32'h8000_1200);
    step();
    wb_ex = 1'b1; wb_ecode = 6'h3F; csr_eentry = 32'hFFFF_FFFF;
    step();
    chk("drop_pc_redir", rif.redirect_pc, 32'h8000_1200);
    chk("drop_cnt_1", 32'(drop_m), 32'h1);
    wb_ex = 1'b1; ertn_flush = 1'b1; set_ready(1'b1);
    step(); wb_ex = 1'b0; ertn_flush = 1'b0;
    chk("drop_cnt_2", 32'(drop_m), 32'h2);
    chk("drop_ecode", 32'(ecode_m), 32'h01);
    chk("drop_pc_kept", rif.redirect_pc, 32'h8000_1200);
    chk("drop_ex_cnt", 32'(ex_m), 32'h3);
    chk("drop_valid", 32'(rif.redirect_valid), 32'h0);
    chk("small_ex_cnt", 32'(ex_s), 32'h3);
    chk("small_drop_cnt", 32'(drop_s), 32'h2);

    // Asynchronous reset in the middle of a redirect
    csr_eentry = 32'h0000_0ABC; wb_ex = 1'b1; wb_ecode = 6'h07; set_ready(1'b0);
    exp_q.push_back(32'h0000_0A80);
    step(); wb_ex = 1'b0;
    step();
    chk("arst_pre_valid", 32'(rif.redirect_valid), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(rif.redirect_valid), 32'h0);
    chk("arst_busy", 32'(busy_m), 32'h0);
    chk("arst_pc", rif.redirect_pc, 32'h0);
    chk("arst_cnts", 32'(ex_m) | 32'(drop_m) | 32'(ex_s) | 32'(ecode_m), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #3 resetn = 1'b1;
    set_ready(1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_quiet", 32'(rif.redirect_valid) | 32'(flush_m) | 32'(busy_m), 32'h0);
    end

    // Five fully handshaken exceptions saturate the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      csr_eentry = 32'h1C00_0000 + 32'(k * 32'h100) + 32'h3F;
      wb_ex = 1'b1; wb_ecode = 6'(k);
      exp_q.push_back(32'h1C00_0000 + 32'(k * 32'h100));
      step(); wb_ex = 1'b0;
      step();
      step();
      step();
    end
    chk("sat_main_ex", 32'(ex_m), 32'h5);
    chk("sat_small_ex", 32'(ex_s), 32'h3);
    chk("sat_ecode", 32'(ecode_m), 32'h4);
    chk("sat_ertn", 32'(ertn_s), 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
